// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding
// and BCD digit clamping.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle between the front-panel logic (master) and the
// countdown timer (slave).
interface bcd_countdown_timer_if #(
  parameter int NUM_DIGITS = 3
);
  localparam int W = 4 * NUM_DIGITS;

  logic                  LOAD_I;
  logic [W-1:0]          PRESET_I;
  logic                  START_I;
  logic                  PAUSE_I;
  logic                  TICK_O;
  logic [W-1:0]          TIM_O;
  logic [NUM_DIGITS-1:0] BORROW_O;
  logic                  RUNNING_O;
  logic                  TIMEOUT_O;

  modport master (
    output LOAD_I, PRESET_I, START_I, PAUSE_I,
    input  TICK_O, TIM_O, BORROW_O, RUNNING_O, TIMEOUT_O
  );

  modport slave (
    input  LOAD_I, PRESET_I, START_I, PAUSE_I,
    output TICK_O, TIM_O, BORROW_O, RUNNING_O, TIMEOUT_O
  );
endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit: loads a clamped value, decrements on dec_en
// and wraps 0 -> 9 with a same-cycle borrow.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       CLK_I,
  input  logic       SW_RESET_I,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] r_q;

  always_ff @(posedge CLK_I) begin
    if (SW_RESET_I) begin
      r_q <= RESET_VAL;
    end else if (load) begin
      r_q <= bcd_clamp(load_val);
    end else if (dec_en) begin
      r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q      = r_q;
  assign borrow = dec_en && (r_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer: run/pause/load FSM, tick prescaler and zero
// detect around a chain of bcd_down_digit counters.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                      NUM_DIGITS   = 3,
  parameter int                      TICK_DIV     = 50_000_000,
  parameter logic [4*NUM_DIGITS-1:0] RESET_PRESET = 12'h020
) (
  input  logic                  CLK_I,
  input  logic                  SW_RESET_I,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  timer_state_t          r_state;
  logic [PW-1:0]         r_presc;
  logic                  r_timeout;

  logic                  w_tick;
  logic                  w_dec;
  logic                  w_is_zero;
  logic                  w_is_one;
  logic [W-1:0]          w_tim;
  logic [NUM_DIGITS-1:0] w_dec_en;
  logic [NUM_DIGITS-1:0] w_borrow;
  logic [NUM_DIGITS-1:0] w_digit_zero;

  assign w_tick    = (r_state == ST_RUN) && (r_presc == P_LAST);
  // A tick that coincides with LOAD or PAUSE is swallowed: no decrement.
  assign w_dec     = w_tick && !bus.LOAD_I && !bus.PAUSE_I;
  assign w_is_zero = ~|w_tim;
  assign w_is_one  = (w_tim == W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsb
        assign w_dec_en[gi] = w_dec;
      end else begin : g_chain
        assign w_dec_en[gi] = w_dec_en[gi-1] && w_digit_zero[gi-1];
      end

      bcd_down_digit #(
        .RESET_VAL (RESET_PRESET[4*gi +: 4])
      ) u_digit (
        .CLK_I      (CLK_I),
        .SW_RESET_I (SW_RESET_I),
        .load       (bus.LOAD_I),
        .load_val   (bus.PRESET_I[4*gi +: 4]),
        .dec_en     (w_dec_en[gi]),
        .q          (w_tim[4*gi +: 4]),
        .borrow     (w_borrow[gi])
      );

      assign w_digit_zero[gi] = (w_tim[4*gi +: 4] == 4'd0);
    end
  endgenerate

  always_ff @(posedge CLK_I) begin
    if (SW_RESET_I) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_timeout <= 1'b0;
    end else if (bus.LOAD_I) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // Pause freezes the prescaler so a resume finishes the partial tick.
          if (bus.PAUSE_I) begin
            r_state <= ST_PAUSED;
          end else begin
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
            if (w_tick && w_is_one) begin
              r_state   <= ST_EXPIRED;
              r_timeout <= 1'b1;
            end
          end
        end
        ST_IDLE, ST_PAUSED: begin
          if (bus.START_I) begin
            if (w_is_zero) begin
              r_state   <= ST_EXPIRED;
              r_timeout <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.TICK_O    = w_tick;
  assign bus.TIM_O     = w_tim;
  assign bus.BORROW_O  = w_borrow;
  assign bus.RUNNING_O = (r_state == ST_RUN);
  assign bus.TIMEOUT_O = r_timeout;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with NUM_DIGITS=3, TICK_DIV=4.
module tb_bcd_countdown_timer;

  typedef struct {
    logic        load;
    logic [11:0] preset;
    logic        start;
    logic        pause;
    logic [11:0] e_tim;
    logic        e_run;
    logic        e_to;
    logic        e_tick;
    logic [2:0]  e_borrow;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  int   split_idx;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.NUM_DIGITS(3)) bus ();

  bcd_countdown_timer #(
    .NUM_DIGITS   (3),
    .TICK_DIV     (4),
    .RESET_PRESET (12'h020)
  ) dut (
    .CLK_I      (clk),
    .SW_RESET_I (rst),
    .bus        (bus)
  );

  function automatic vec_t mk(input logic l, input logic [11:0] p, input logic s,
                              input logic pa, input logic [11:0] t, input logic r,
                              input logic to, input logic tk, input logic [2:0] b);
    vec_t v;
    v.load = l; v.preset = p; v.start = s; v.pause = pa;
    v.e_tim = t; v.e_run = r; v.e_to = to; v.e_tick = tk; v.e_borrow = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [11:0] p, input logic s, input logic pa);
    bus.LOAD_I   = l;
    bus.PRESET_I = p;
    bus.START_I  = s;
    bus.PAUSE_I  = pa;
  endtask

  // Outputs are sampled 1 time unit after the edge with all inputs released.
  task automatic edge_();
    @(posedge clk);
    #1;
    drive(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [11:0] t, input logic r,
                            input logic to, input logic tk, input logic [2:0] b);
    chk({tag, ".tim"},     32'(bus.TIM_O),     32'(t));
    chk({tag, ".running"}, 32'(bus.RUNNING_O), 32'(r));
    chk({tag, ".timeout"}, 32'(bus.TIMEOUT_O), 32'(to));
    chk({tag, ".tick"},    32'(bus.TICK_O),    32'(tk));
    chk({tag, ".borrow"},  32'(bus.BORROW_O),  32'(b));
  endtask

  task automatic step(input string tag, input logic l, input logic [11:0] p, input logic s,
                      input logic pa, input logic [11:0] t, input logic r, input logic to,
                      input logic tk, input logic [2:0] b);
    drive(l, p, s, pa);
    edge_();
    expect_out(tag, t, r, to, tk, b);
  endtask

  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    step(tag, vecs[i].load, vecs[i].preset, vecs[i].start, vecs[i].pause,
         vecs[i].e_tim, vecs[i].e_run, vecs[i].e_to, vecs[i].e_tick, vecs[i].e_borrow);
  endtask

  initial begin
    logic [11:0] cnt_vals [6];
    logic [11:0] prev;
    int          tick_seen;

    // LOAD 002 -> START -> expiry after 8 cycles
    vecs.push_back(mk(1, 12'h002, 0, 0, 12'h002, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h002, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h002, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h002, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h002, 1, 0, 1, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h001, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h001, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h001, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h001, 1, 0, 1, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 3'b000));
    split_idx = vecs.size();
    // START ignored in EXPIRED, zero start, clamp, LOAD priority in RUN
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 1, 0, 3'b000));
    vecs.push_back(mk(1, 12'h000, 0, 0, 12'h000, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 1, 0, 3'b000));
    vecs.push_back(mk(1, 12'h1A3, 0, 0, 12'h193, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 12'h0F0, 0, 0, 12'h090, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h090, 1, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h090, 1, 0, 0, 3'b000));
    vecs.push_back(mk(1, 12'h321, 1, 1, 12'h321, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h321, 0, 0, 0, 3'b000));

    // Reset held for 3 cycles
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 12'h020, 1'b0, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < 20; i++) begin
      edge_();
      if (bus.TICK_O !== 1'b0) tick_seen++;
    end
    chk("idle_no_tick", 32'(tick_seen), 32'd0);
    chk("idle_tim", 32'(bus.TIM_O), 32'h020);

    // LOAD 105, START, count down to 099
    step("ld105", 1, 12'h105, 0, 0, 12'h105, 0, 0, 0, 3'b000);
    step("st105", 0, 12'h000, 1, 0, 12'h105, 1, 0, 0, 3'b000);
    cnt_vals[0] = 12'h104; cnt_vals[1] = 12'h103; cnt_vals[2] = 12'h102;
    cnt_vals[3] = 12'h101; cnt_vals[4] = 12'h100; cnt_vals[5] = 12'h099;
    prev = 12'h105;
    for (int k = 0; k < 6; k++) begin
      for (int c = 1; c <= 3; c++) begin
        edge_();
        expect_out($sformatf("cnt%0d_c%0d", k, c), prev, 1'b1, 1'b0, c == 3,
                   (c == 3 && prev == 12'h100) ? 3'b011 : 3'b000);
      end
      edge_();
      expect_out($sformatf("cnt%0d_dec", k), cnt_vals[k], 1'b1, 1'b0, 1'b0, 3'b000);
      prev = cnt_vals[k];
    end

    for (int i = 0; i < split_idx; i++) run_vec(i);
    for (int i = 0; i < 40; i++) begin
      edge_();
      if (bus.TIM_O !== 12'h000 || bus.TIMEOUT_O !== 1'b1 || bus.RUNNING_O !== 1'b0)
        chk($sformatf("expired_hold%0d", i), {bus.TIM_O, bus.TIMEOUT_O, bus.RUNNING_O},
            {12'h000, 1'b1, 1'b0});
    end
    chk("expired_hold_end", 32'({bus.TIM_O, bus.TIMEOUT_O}), 32'({12'h000, 1'b1}));
    for (int i = split_idx; i < vecs.size(); i++) run_vec(i);

    // Pause mid-tick, resume continues the partial tick
    step("p_ld",    1, 12'h010, 0, 0, 12'h010, 0, 0, 0, 3'b000);
    step("p_st",    0, 12'h000, 1, 0, 12'h010, 1, 0, 0, 3'b000);
    step("p_c1",    0, 12'h000, 0, 0, 12'h010, 1, 0, 0, 3'b000);
    step("p_c2",    0, 12'h000, 0, 0, 12'h010, 1, 0, 0, 3'b000);
    step("p_pause", 0, 12'h000, 0, 1, 12'h010, 0, 0, 0, 3'b000);
    for (int i = 0; i < 10; i++)
      step($sformatf("p_hold%0d", i), 0, 12'h000, 0, 0, 12'h010, 0, 0, 0, 3'b000);
    step("p_resume", 0, 12'h000, 1, 0, 12'h010, 1, 0, 0, 3'b000);
    step("p_tick",   0, 12'h000, 0, 0, 12'h010, 1, 0, 1, 3'b001);
    step("p_009",    0, 12'h000, 0, 0, 12'h009, 1, 0, 0, 3'b000);
    step("p_c1b",    0, 12'h000, 0, 0, 12'h009, 1, 0, 0, 3'b000);
    step("p_c2b",    0, 12'h000, 0, 0, 12'h009, 1, 0, 0, 3'b000);
    step("p_c3b",    0, 12'h000, 0, 0, 12'h009, 1, 0, 1, 3'b000);
    // Pause asserted in the tick cycle: tick visible, no borrow, no decrement
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    #1;
    chk("pt_tick",   32'(bus.TICK_O),   32'd1);
    chk("pt_borrow", 32'(bus.BORROW_O), 32'd0);
    edge_();
    expect_out("pt_paused", 12'h009, 1'b0, 1'b0, 1'b0, 3'b000);
    step("pt_resume", 0, 12'h000, 1, 0, 12'h009, 1, 0, 1, 3'b000);
    step("pt_dec",    0, 12'h000, 0, 0, 12'h008, 1, 0, 0, 3'b000);

    // Reset during RUN, then reset out of EXPIRED
    drive(1'b0, 12'h000, 1'b1, 1'b0);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    expect_out("rst_run", 12'h020, 1'b0, 1'b0, 1'b0, 3'b000);
    step("re_ld", 1, 12'h000, 0, 0, 12'h000, 0, 0, 0, 3'b000);
    step("re_st", 0, 12'h000, 1, 0, 12'h000, 0, 1, 0, 3'b000);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    expect_out("rst_exp", 12'h020, 1'b0, 1'b0, 1'b0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
